// File: rtl/cell_ram_ctrl_pkg.sv
// Shared types and default sizes for the binary-cell memory controller.
package cell_ram_ctrl_pkg;

    localparam int CRC_ADDR_W = 2;
    localparam int CRC_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/cell_ram_ctrl_if.sv
// Host-side request/acknowledge bus of the binary-cell memory controller.
interface cell_ram_ctrl_if #(
    parameter int ADDR_W = cell_ram_ctrl_pkg::CRC_ADDR_W,
    parameter int DATA_W = cell_ram_ctrl_pkg::CRC_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input busy, ack, rdata);
    modport slave  (input req, we, addr, wdata, output busy, ack, rdata);
endinterface

// File: rtl/cell_ram_ctrl_cell_word.sv
// One storage word made of independent binary cells; dout is zero unless
// the word is selected with a clean read strobe.
module cell_word
    import cell_ram_ctrl_pkg::*;
#(
    parameter int DATA_W = CRC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              cs,
    input  logic              w,
    input  logic              r,
    output logic [DATA_W-1:0] dout
);

    logic do_store;
    logic do_read;

    // w and r together is treated as neither, so a glitchy strobe pair cannot corrupt a cell
    assign do_store = cs & w & ~r;
    assign do_read  = cs & r & ~w;

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic bit_q;
        logic bit_d;

        always_comb begin
            bit_d = bit_q;
            if (do_store) bit_d = din[b];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) bit_q <= 1'b0;
            else        bit_q <= bit_d;
        end

        assign dout[b] = do_read ? bit_q : 1'b0;
    end

endmodule

// File: rtl/cell_ram_ctrl.sv
// Single-access controller sequencing cs/w/r strobes into an array of
// binary-cell words and returning read data to the host.
module cell_ram_ctrl
    import cell_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = CRC_ADDR_W,
    parameter int DATA_W = CRC_DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    cell_ram_ctrl_if.slave  host,
    output logic            cell_cs,
    output logic            cell_w,
    output logic            cell_r
);

    // state  | meaning
    // IDLE   | waiting for req; request fields latched on acceptance
    // SELECT | chip select up, no strobe
    // ACCESS | chip select plus exactly one of write/read strobe
    // DONE   | ack pulse, strobes released

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy;
    logic              ack;

    logic [DEPTH-1:0]  word_cs;
    logic [DATA_W-1:0] word_dout [DEPTH];
    logic [DATA_W-1:0] dout_or;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy    = 1'b1;
        ack     = 1'b0;
        cell_cs = 1'b0;
        cell_w  = 1'b0;
        cell_r  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (host.req) begin
                    we_d    = host.we;
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                cell_cs = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                cell_cs = 1'b1;
                cell_w  = we_q;
                cell_r  = ~we_q;
                if (!we_q) rdata_d = dout_or;
                state_d = DONE;
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_cs         = '0;
        word_cs[addr_q] = cell_cs;
    end

    // unselected words drive zero, so a plain OR acts as the read mux
    always_comb begin
        dout_or = '0;
        for (int i = 0; i < DEPTH; i++) dout_or = dout_or | word_dout[i];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        cell_word #(.DATA_W(DATA_W)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (wdata_q),
            .cs    (word_cs[g]),
            .w     (cell_w),
            .r     (cell_r),
            .dout  (word_dout[g])
        );
    end

    assign host.busy  = busy;
    assign host.ack   = ack;
    assign host.rdata = rdata_q;

endmodule

// File: tb/tb_cell_ram_ctrl.sv
// Self-checking bench for cell_ram_ctrl: directed vector table, corner
// sequences and random traffic against a word-array reference model.
module tb_cell_ram_ctrl;

    logic clk;
    logic rst_n;
    logic cell_cs, cell_w, cell_r;

    cell_ram_ctrl_if host ();

    cell_ram_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (host),
        .cell_cs (cell_cs),
        .cell_w  (cell_w),
        .cell_r  (cell_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] mem [4];
    logic [3:0] m_rdata;

    typedef struct {
        bit         we;
        logic [1:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 4'h0;
        m_rdata = 4'h0;
    endtask

    // caller is 1 time unit after an edge with the DUT in IDLE
    task automatic do_txn(input bit w, input logic [1:0] a, input logic [3:0] d,
                          output logic [3:0] got);
        host.req   = 1'b1;
        host.we    = w;
        host.addr  = a;
        host.wdata = d;
        next_cycle();
        host.req   = 1'b0;
        host.we    = 1'($urandom);
        host.addr  = 2'($urandom);
        host.wdata = 4'($urandom);
        check("select_phase", {host.busy, host.ack, cell_cs, cell_w, cell_r}, 5'b10100);
        next_cycle();
        check("access_phase", {host.busy, host.ack, cell_cs, cell_w, cell_r},
              {3'b101, w, ~w});
        next_cycle();
        check("done_phase", {host.busy, host.ack, cell_cs, cell_w, cell_r}, 5'b11000);
        if (w) mem[a] = d;
        else   m_rdata = mem[a];
        check(w ? "rdata_after_write" : "rdata_read", host.rdata, m_rdata);
        got = host.rdata;
        next_cycle();
        check("back_to_idle", {host.busy, host.ack}, 2'b00);
    endtask

    initial begin
        logic [3:0] got;
        logic [1:0] b2b_addr [3];
        logic [3:0] b2b_data [3];
        int         ack_cnt;

        vecs[0] = '{1'b0, 2'd3, 4'h0, 4'h0};
        vecs[1] = '{1'b1, 2'd0, 4'h5, 4'h0};
        vecs[2] = '{1'b1, 2'd2, 4'hC, 4'h0};
        vecs[3] = '{1'b0, 2'd0, 4'h0, 4'h5};
        vecs[4] = '{1'b0, 2'd2, 4'h0, 4'hC};
        vecs[5] = '{1'b0, 2'd1, 4'h0, 4'h0};
        vecs[6] = '{1'b1, 2'd1, 4'hA, 4'h0};
        vecs[7] = '{1'b0, 2'd1, 4'h0, 4'hA};

        host.req = 1'b0; host.we = 1'b0; host.addr = '0; host.wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {host.busy, host.ack, cell_cs, cell_w, cell_r}, 5'b0);
        check("reset_rdata", host.rdata, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, got);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
        end

        // req pulsed while busy must be dropped
        host.req = 1'b1; host.we = 1'b0; host.addr = 2'd0; host.wdata = 4'h0;
        next_cycle();
        host.req = 1'b1; host.we = 1'b1; host.addr = 2'd3; host.wdata = 4'hF;
        next_cycle();
        host.req = 1'b0;
        check("rej_access", {cell_cs, cell_w, cell_r}, 3'b101);
        next_cycle();
        m_rdata = mem[0];
        check("rej_done", {host.ack, host.rdata}, {1'b1, m_rdata});
        next_cycle();
        check("rej_idle", host.busy, 1'b0);
        next_cycle();
        check("rej_no_second", {host.busy, cell_cs}, 2'b00);
        do_txn(1'b0, 2'd3, 4'h0, got);
        check("rej_addr3", got, 4'h0);

        // back-to-back writes with req held high
        b2b_addr[0] = 2'd3; b2b_data[0] = 4'h7;
        b2b_addr[1] = 2'd2; b2b_data[1] = 4'h9;
        b2b_addr[2] = 2'd1; b2b_data[2] = 4'h3;
        ack_cnt = 0;
        host.req = 1'b1; host.we = 1'b1;
        host.addr = b2b_addr[0]; host.wdata = b2b_data[0];
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            check("b2b_strobe_excl", cell_w & cell_r, 1'b0);
            check($sformatf("b2b_ack_k%0d", k), host.ack, (k % 4) == 3);
            check($sformatf("b2b_busy_k%0d", k), host.busy, (k % 4) != 0);
            if (host.ack) ack_cnt++;
            if (k == 1 || k == 5) begin
                host.addr  = b2b_addr[(k / 4) + 1];
                host.wdata = b2b_data[(k / 4) + 1];
            end
            if (k == 9) host.req = 1'b0;
        end
        check("b2b_ack_count", ack_cnt, 3);
        for (int i = 0; i < 3; i++) mem[b2b_addr[i]] = b2b_data[i];
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b0, b2b_addr[i], 4'h0, got);
            check($sformatf("b2b_read%0d", i), got, b2b_data[i]);
        end

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), 2'($urandom), 4'($urandom), got);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        // reset during SELECT of a write aborts without committing
        host.req = 1'b1; host.we = 1'b1; host.addr = 2'd2; host.wdata = 4'h9;
        next_cycle();
        check("midrst_in_select", cell_cs, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {host.busy, host.ack, cell_cs, cell_w, cell_r}, 5'b0);
        check("midrst_rdata", host.rdata, 4'h0);
        model_reset();
        host.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        do_txn(1'b0, 2'd2, 4'h0, got);
        check("midrst_read2", got, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_ram_ctrl.md
# cell_ram_ctrl

Access controller and storage array for the binary-cell memory. Accepts single-word read/write requests from a host over a req/ack handshake and sequences the chip-select, write and read strobes into an array of binary-cell words, one access at a time. It is the initiator that drives the cell-level cs/w/r interface, and it returns read data to the host.

## Interface

- ADDR_W, 2, word-address width; depth = 2**ADDR_W words
- DATA_W, 4, bits per word (one binary cell per bit)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  host request; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- busy  out  1  high from the cycle after acceptance through DONE
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result; valid when ack=1 after a read
- cell_cs  out  1  chip select driven to the selected word (observability)
- cell_w  out  1  write strobe to the selected word
- cell_r  out  1  read strobe to the selected word

## Operation

- FSM states: IDLE, SELECT, ACCESS, DONE.
- IDLE: if req=1 at a rising edge, latch we, addr and wdata, then go to SELECT. Otherwise stay in IDLE.
- SELECT: cell_cs=1, cell_w=0, cell_r=0. Always go to ACCESS.
- ACCESS: cell_cs=1. cell_w=we_q and cell_r=~we_q, so exactly one strobe is high. Always go to DONE.
- DONE: ack=1, all cell strobes are 0. Always go to IDLE.
- Cell rule, per bit: on a rising edge with cs=1, w=1 and r=0, store DIn. DOut = stored when cs=1, r=1 and w=0; otherwise DOut=0.
- Only the word at addr_q sees cs. All other words see cs=0.
- w and r are never high together. The cell rule also ignores that combination defensively.
- rdata: in ACCESS with a read, capture DOut of the selected word at the ACCESS→DONE edge. rdata is unchanged after writes and holds its value until the next read.
- busy = 1 in SELECT, ACCESS and DONE.
- req is ignored while busy. A req held high through DONE is accepted again in the next IDLE cycle, so back-to-back accesses run every 4 cycles.
- Host inputs may change freely after acceptance; only the latched copies are used.

## Timing

- Reset values (async, on rst_n low): state=IDLE; busy, ack, cell_cs, cell_w and cell_r all 0; rdata=0; every stored cell bit 0.
- Reset asserted mid-access: the block aborts immediately. The addressed word may hold either the old or new value only if reset coincides with the ACCESS→DONE edge. Otherwise it keeps its old value.
- Latency: req accepted at edge E0. SELECT holds during (E0,E1], ACCESS during (E1,E2], and ack=1 during (E2,E3].
- Write commit happens at edge E2.
- Read: rdata is valid from E2 together with ack.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Address wrap: none. All 2**ADDR_W addresses are legal.

## Structure

- Shared package holds:
  - the FSM state enum: IDLE=2'd0, SELECT=2'd1, ACCESS=2'd2, DONE=2'd3
  - default ADDR_W and DATA_W constants
- Sub-module cell_word:
  - one DATA_W-wide word built from per-bit cells
  - ports: clk, rst_n, din, cs, w, r, dout
  - instantiated 2**ADDR_W times with a generate loop
- Top-level contents:
  - FSM
  - request latches
  - address decode to the per-word cs
  - read-data OR-reduction over all words (non-selected words output 0)
  - rdata register

## Test plan

- Reset: hold rst_n=0 for 2 cycles → busy=0, ack=0, rdata=0, all strobes 0. A read of addr 3 then returns 4'h0.
- Write then read: write addr=1, wdata=4'hA → ack exactly 3 cycles after acceptance, cell_w high for one cycle only. Then read addr=1 → rdata=4'hA with ack.
- Isolation: write addr 0=4'h5, addr 2=4'hC, then read addr 0 and addr 2 → 4'h5 and 4'hC. Read addr 1 → 4'h0.
- Busy rejection: pulse req in SELECT with we=1, addr=3, wdata=4'hF → no second transaction. A later read of addr 3 gives 4'h0.
- Back-to-back: hold req=1 for 3 writes → acks every 4 cycles, cell_w and cell_r never high together.
- Reset mid-op: rst_n low during SELECT of a write to addr 2 = 4'h9 → outputs return to their reset values at once. A read of addr 2 after release gives 4'h0.
